pixel_packer: RTL and testbench
===============================

Name: pixel_packer

Overview:
- Frame-level packer on the output side of crop_norm.
- Accepts the single-pixel AXI-Stream of normalized, cropped pixels (OUT_ROWS*OUT_COLS pixels per frame) and packs them into wide PIXELS_PER_BURST-pixel words for the host/DMA path.
- Performs the inverse of the Mono8 sequentializer.
- Uses the same ap_start/ap_ready/ap_done frame handshake as the rest of the pipeline.

Parameters:
- PIXEL_BIT_WIDTH, 10: bits per pixel.
- PIXELS_PER_BURST, 8: pixels per output word (power of 2, ≥2).
- OUT_ROWS, 10: cropped frame rows.
- OUT_COLS, 10: cropped frame columns.

Ports:
- clk  in  1  single clock domain.
- s_axis_resetn  in  1  reset, asynchronous, active-low.
- ap_start  in  1  request to pack one frame.
- ap_ready  out  1  block can accept ap_start.
- ap_idle  out  1  block in IDLE.
- ap_done  out  1  one-cycle pulse when the frame's last word is handshaked.
- s_axis_tvalid  in  1  input pixel valid.
- s_axis_tready  out  1  input pixel accepted.
- s_axis_tdata  in  PIXEL_BIT_WIDTH  input pixel.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  PIXELS_PER_BURST*PIXEL_BIT_WIDTH  packed word; pixel k occupies bits [k*PW +: PW], first pixel at LSBs.
- m_axis_tkeep  out  PIXELS_PER_BURST  one bit per pixel lane.
- m_axis_tlast  out  1  last word of the frame.

Behaviour:
- Definitions:
  - N = OUT_ROWS*OUT_COLS.
  - W = ceil(N/PIXELS_PER_BURST) words per frame.
  - R = N mod PIXELS_PER_BURST (0 means a full last word).
- Reset (asynchronous assert, synchronous release): state=IDLE; all counters 0; pack and output registers 0; m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, ap_done=0, s_axis_tready=0, ap_ready=1, ap_idle=1.
- IDLE:
  - ap_ready=1, ap_idle=1, s_axis_tready=0.
  - On ap_start: clear pixel counter, lane counter and word counter; go to RUN next cycle.
- RUN:
  - s_axis_tready = !pending.
  - Each accepted pixel is written to lane lane_cnt; lane_cnt and pix_cnt increment.
  - A word is complete when lane_cnt==PIXELS_PER_BURST-1, or when pix_cnt==N-1 (frame's last pixel).
- Word transfer:
  - On completion, the pack register moves to the output register in the same cycle if the output register is empty or being drained (m_axis_tvalid && m_axis_tready).
  - Otherwise set pending; s_axis_tready=0 until the transfer occurs.
  - Unused lanes of a partial last word are zero-filled.
- Output word fields:
  - tkeep is all ones for full words.
  - For a partial last word, tkeep = (1<<R)-1.
  - tlast=1 only on word W-1.
- Latency and throughput:
  - The completing pixel is accepted at edge t; m_axis_tvalid=1 from cycle t+1.
  - Sustained throughput is 1 pixel/cycle with m_axis_tready held high.
- Output register:
  - Holds data stable while m_axis_tvalid && !m_axis_tready (AXI rule).
  - m_axis_tvalid never drops without a handshake.
- After the last pixel is accepted, go to FLUSH; s_axis_tready=0.
- FLUSH: when the tlast word handshakes, pulse ap_done for 1 cycle and return to IDLE.
- ap_start is ignored outside IDLE. ap_ready=0 in RUN and FLUSH.
- Input pixels presented outside RUN are not accepted; they remain upstream.
- Reset asserted mid-frame: immediate return to reset state; partial word discarded; no ap_done.
- Back-to-back frames: ap_start held high on the ap_done cycle starts the next frame on the following cycle (IDLE for 1 cycle).

Test Plan:
- Defaults, 100 pixels with values 0..99, tready=1 → 13 words; word0 lanes = 0..7; word12 lanes 0..3 = 96..99, lanes 4..7 = 0, tkeep=0x0F, tlast=1; ap_done pulses exactly once, 1 cycle after the word12 handshake.
- OUT_ROWS=4, OUT_COLS=4 (N=16) → 2 words, both tkeep=0xFF; tlast on word1 only.
- m_axis_tready=0 for 20 cycles starting mid-frame → s_axis_tready falls after at most 2 further words are packed; output data is held stable; no pixel lost or duplicated once tready returns.
- Random s_axis_tvalid (50%) and random m_axis_tready (50%), 3 back-to-back frames → output matches the reference packing of each frame; exactly 3 ap_done pulses.
- ap_start pulsed during RUN → ignored; frame completes normally; ap_ready=0 throughout.
- s_axis_resetn asserted after 37 pixels accepted → all outputs go to reset values asynchronously; a new frame then packs correctly from lane 0.

Source files
------------

// File: rtl/pixel_packer.sv
// Packs a single-pixel AXI-Stream frame into PIXELS_PER_BURST-wide words with per-lane
// tkeep and a frame-final tlast, framed by the ap_start/ap_ready/ap_done handshake.
module pixel_packer #(
    parameter int PIXEL_BIT_WIDTH  = 10,
    parameter int PIXELS_PER_BURST = 8,
    parameter int OUT_ROWS         = 10,
    parameter int OUT_COLS         = 10
) (
    input  logic                                         clk,
    input  logic                                         s_axis_resetn,
    input  logic                                         ap_start,
    output logic                                         ap_ready,
    output logic                                         ap_idle,
    output logic                                         ap_done,
    input  logic                                         s_axis_tvalid,
    output logic                                         s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0]                   s_axis_tdata,
    output logic                                         m_axis_tvalid,
    input  logic                                         m_axis_tready,
    output logic [PIXELS_PER_BURST*PIXEL_BIT_WIDTH-1:0]  m_axis_tdata,
    output logic [PIXELS_PER_BURST-1:0]                  m_axis_tkeep,
    output logic                                         m_axis_tlast
);
    localparam int PW      = PIXEL_BIT_WIDTH;
    localparam int PPB     = PIXELS_PER_BURST;
    localparam int DW      = PPB * PW;
    localparam int N       = OUT_ROWS * OUT_COLS;
    localparam int W       = (N + PPB - 1) / PPB;
    localparam int R       = N % PPB;
    localparam int PIX_CW  = (N > 1) ? $clog2(N + 1) : 1;
    localparam int LANE_CW = $clog2(PPB);
    localparam int WORD_CW = (W > 1) ? $clog2(W + 1) : 1;

    localparam logic [PIX_CW-1:0]  LAST_PIX  = PIX_CW'(N - 1);
    localparam logic [LANE_CW-1:0] LAST_LANE = LANE_CW'(PPB - 1);
    localparam logic [WORD_CW-1:0] LAST_WORD = WORD_CW'(W - 1);
    localparam logic [PPB-1:0]     KEEP_FULL = {PPB{1'b1}};
    localparam logic [PPB-1:0]     KEEP_TAIL = (R == 0) ? KEEP_FULL : PPB'((32'd1 << R) - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [PIX_CW-1:0]  pix_cnt_r;
    logic [LANE_CW-1:0] lane_cnt_r;
    logic [WORD_CW-1:0] word_cnt_r;
    logic [DW-1:0]      pack_r;
    logic               pend_r;
    logic [PPB-1:0]     pend_keep_r;
    logic               pend_last_r;
    logic [DW-1:0]      out_data_r;
    logic [PPB-1:0]     out_keep_r;
    logic               out_last_r;
    logic               out_valid_r;
    logic               done_r;

    logic               start_s;
    logic               accept_s;
    logic               last_pix_s;
    logic               complete_s;
    logic               out_free_s;
    logic               drain_s;
    logic               load_new_s;
    logic               load_pend_s;
    logic [PPB-1:0]     cmpl_keep_s;
    logic               cmpl_last_s;
    logic [DW-1:0]      word_s;

    assign start_s     = (state_r == ST_IDLE) && ap_start;
    assign accept_s    = (state_r == ST_RUN) && !pend_r && s_axis_tvalid;
    assign last_pix_s  = (pix_cnt_r == LAST_PIX);
    assign complete_s  = accept_s && ((lane_cnt_r == LAST_LANE) || last_pix_s);
    assign drain_s     = out_valid_r && m_axis_tready;
    assign out_free_s  = !out_valid_r || m_axis_tready;
    // A finished word goes straight out when the output slot frees up this cycle,
    // otherwise it parks in the pack register and stalls the input.
    assign load_new_s  = complete_s && out_free_s;
    assign load_pend_s = pend_r && out_free_s;
    assign cmpl_keep_s = last_pix_s ? KEEP_TAIL : KEEP_FULL;
    assign cmpl_last_s = (word_cnt_r == LAST_WORD);

    // Pack register image with the incoming pixel dropped into the current lane.
    always_comb begin
        word_s = pack_r;
        word_s[lane_cnt_r * PW +: PW] = s_axis_tdata;
    end

    // Frame sequencing: IDLE -> RUN on start, RUN -> FLUSH on the last pixel, FLUSH -> IDLE on tlast handshake.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ap_start) state_s = ST_RUN;
                else          state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (accept_s && last_pix_s) state_s = ST_FLUSH;
                else                        state_s = ST_RUN;
            end
            ST_FLUSH: begin
                if (drain_s && out_last_r) state_s = ST_IDLE;
                else                       state_s = ST_FLUSH;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) state_r <= ST_IDLE;
        else                state_r <= state_s;
    end

    // Pixel, lane and word counters.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            pix_cnt_r  <= '0;
            lane_cnt_r <= '0;
            word_cnt_r <= '0;
        end else if (start_s) begin
            pix_cnt_r  <= '0;
            lane_cnt_r <= '0;
            word_cnt_r <= '0;
        end else if (accept_s) begin
            pix_cnt_r <= pix_cnt_r + PIX_CW'(1);
            if (complete_s) begin
                lane_cnt_r <= '0;
                word_cnt_r <= word_cnt_r + WORD_CW'(1);
            end else begin
                lane_cnt_r <= lane_cnt_r + LANE_CW'(1);
            end
        end
    end

    // Pack register and parked-word bookkeeping; cleared after every hand-off so a short
    // final word leaves zeros in its unused lanes.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            pack_r      <= '0;
            pend_r      <= 1'b0;
            pend_keep_r <= '0;
            pend_last_r <= 1'b0;
        end else if (load_new_s || load_pend_s) begin
            pack_r <= '0;
            pend_r <= 1'b0;
        end else if (complete_s) begin
            pack_r      <= word_s;
            pend_r      <= 1'b1;
            pend_keep_r <= cmpl_keep_s;
            pend_last_r <= cmpl_last_s;
        end else if (accept_s) begin
            pack_r <= word_s;
        end
    end

    // Output register: loads only when empty or draining, so data holds under backpressure.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) begin
            out_data_r  <= '0;
            out_keep_r  <= '0;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (load_new_s) begin
            out_data_r  <= word_s;
            out_keep_r  <= cmpl_keep_s;
            out_last_r  <= cmpl_last_s;
            out_valid_r <= 1'b1;
        end else if (load_pend_s) begin
            out_data_r  <= pack_r;
            out_keep_r  <= pend_keep_r;
            out_last_r  <= pend_last_r;
            out_valid_r <= 1'b1;
        end else if (drain_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    // One-cycle frame-done pulse following the tlast handshake.
    always_ff @(posedge clk or negedge s_axis_resetn) begin
        if (!s_axis_resetn) done_r <= 1'b0;
        else                done_r <= (state_r == ST_FLUSH) && drain_s && out_last_r;
    end

    assign ap_ready      = (state_r == ST_IDLE);
    assign ap_idle       = (state_r == ST_IDLE);
    assign ap_done       = done_r;
    assign s_axis_tready = (state_r == ST_RUN) && !pend_r;
    assign m_axis_tvalid = out_valid_r;
    assign m_axis_tdata  = out_data_r;
    assign m_axis_tkeep  = out_keep_r;
    assign m_axis_tlast  = out_last_r;

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer: default 10x10 frame plus a 4x4 instance, with
// backpressure, random handshakes, back-to-back frames and mid-frame reset.
module tb_pixel_packer;
    localparam int PW  = 10;
    localparam int PPB = 8;
    localparam int DW  = PW * PPB;
    localparam int N   = 100;
    localparam int W   = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, ap_start, ap_ready, ap_idle, ap_done;
    logic          s_tvalid, s_tready, m_tvalid, m_tready, m_tlast;
    logic [PW-1:0] s_tdata;
    logic [DW-1:0] m_tdata;
    logic [PPB-1:0] m_tkeep;

    logic          b_ap_start, b_ap_ready, b_ap_idle, b_ap_done;
    logic          b_s_tvalid, b_s_tready, b_m_tvalid, b_m_tlast;
    logic [PW-1:0] b_s_tdata;
    logic [DW-1:0] b_m_tdata;
    logic [PPB-1:0] b_m_tkeep;

    pixel_packer dut (
        .clk(clk), .s_axis_resetn(rst_n), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_idle(ap_idle), .ap_done(ap_done), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tdata(s_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
        .m_axis_tlast(m_tlast)
    );

    pixel_packer #(.OUT_ROWS(4), .OUT_COLS(4)) dut_b (
        .clk(clk), .s_axis_resetn(rst_n), .ap_start(b_ap_start), .ap_ready(b_ap_ready),
        .ap_idle(b_ap_idle), .ap_done(b_ap_done), .s_axis_tvalid(b_s_tvalid),
        .s_axis_tready(b_s_tready), .s_axis_tdata(b_s_tdata), .m_axis_tvalid(b_m_tvalid),
        .m_axis_tready(1'b1), .m_axis_tdata(b_m_tdata), .m_axis_tkeep(b_m_tkeep),
        .m_axis_tlast(b_m_tlast)
    );

    int n_checks = 0;
    int n_err    = 0;

    // observation state (written by the negedge monitor)
    logic [DW+PPB:0] wq[$];
    logic [DW+PPB:0] bq[$];
    int cyc = 0, done_cnt = 0, b_done = 0, acc_cnt = 0, gap_idle = 0;
    int first_acc = -1, last_acc = -1, first_hs = -1, last_hs = -1, done_cyc = -1;
    int hold_viol = 0, rdy_viol = 0;
    logic hold_prev = 1'b0;
    logic [DW+PPB:0] prev_word;

    // stimulus state
    int pix_val = 0, pix_left = 0, starts_left = 0, v_pct = 100, r_mode = 0;
    logic spam = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev && (!m_tvalid || {m_tlast, m_tkeep, m_tdata} !== prev_word)) hold_viol++;
            hold_prev = m_tvalid && !m_tready;
            prev_word = {m_tlast, m_tkeep, m_tdata};
            if (ap_ready !== ap_idle) rdy_viol++;
            if (m_tvalid && m_tready) begin
                wq.push_back({m_tlast, m_tkeep, m_tdata});
                if (first_hs < 0) first_hs = cyc;
                if (m_tlast) last_hs = cyc;
            end
            if (s_tvalid && s_tready) begin
                acc_cnt++;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
            if (ap_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (ap_idle && done_cnt >= 1 && done_cnt < 3) gap_idle++;
            if (b_m_tvalid) bq.push_back({b_m_tlast, b_m_tkeep, b_m_tdata});
            if (b_ap_done) b_done++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW+PPB:0] exp_word(input int base, input int j, input int n_pix);
        logic [DW-1:0]  d = '0;
        logic [PPB-1:0] k = '0;
        int nw = (n_pix + PPB - 1) / PPB;
        for (int l = 0; l < PPB; l++) begin
            if (j * PPB + l < n_pix) begin
                d[l*PW +: PW] = PW'(base + j * PPB + l);
                k[l] = 1'b1;
            end
        end
        return {(j == nw - 1), k, d};
    endfunction

    task automatic check_frame(input string tag, input int base, input int off);
        logic [DW+PPB:0] got;
        for (int j = 0; j < W; j++) begin
            if (off + j < wq.size()) got = wq[off + j];
            else got = 'x;
            chk($sformatf("%s_w%0d", tag, j), got, exp_word(base, j, N));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk(tag, {ap_ready, ap_idle, s_tready, m_tvalid, m_tlast, ap_done, m_tkeep, m_tdata},
            {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {PPB{1'b0}}, {DW{1'b0}}});
    endtask

    task automatic clear_trk();
        wq.delete();
        done_cnt = 0; acc_cnt = 0; gap_idle = 0; hold_viol = 0; rdy_viol = 0;
        first_acc = -1; last_acc = -1; first_hs = -1; last_hs = -1; done_cyc = -1;
    endtask

    // one clock of main-DUT stimulus; inputs change 1 time unit after the rising edge
    task automatic tick();
        logic acc;
        @(negedge clk);
        acc = s_tvalid && s_tready;
        @(posedge clk);
        #1;
        if (acc) begin
            pix_val++;
            pix_left--;
        end
        if (ap_ready) begin
            ap_start = (starts_left > 0);
            if (starts_left > 0) starts_left--;
        end else begin
            ap_start = spam && ($urandom_range(1) == 1);
        end
        s_tvalid = (pix_left > 0) && (int'($urandom_range(99)) < v_pct);
        s_tdata  = PW'(pix_val);
        case (r_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = ($urandom_range(1) == 1);
            default: m_tready = 1'b0;
        endcase
    endtask

    task automatic run_until_done(input int n, input int budget);
        for (int c = 0; c < budget && done_cnt < n; c++) tick();
    endtask

    initial begin
        int a0;
        rst_n = 1'b0; ap_start = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
        b_ap_start = 1'b0; b_s_tvalid = 1'b0; b_s_tdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        rst_n = 1'b1;

        // frame of 0..99, ready held high
        clear_trk();
        starts_left = 1; pix_left = N; pix_val = 0; v_pct = 100; r_mode = 0;
        run_until_done(1, 300);
        repeat (3) tick();
        chk("f1_done_cnt", done_cnt, 1);
        chk("f1_nwords", wq.size(), W);
        check_frame("f1", 0, 0);
        chk("f1_throughput", last_acc - first_acc, N - 1);
        chk("f1_latency", first_hs - first_acc, PPB);
        chk("f1_done_timing", done_cyc - last_hs, 1);
        chk("f1_ready_vs_idle", rdy_viol, 0);

        // output stalled 20 cycles mid-frame
        clear_trk();
        starts_left = 1; pix_left = N; pix_val = 200;
        for (int c = 0; c < 200 && acc_cnt < 40; c++) tick();
        a0 = acc_cnt;
        r_mode = 2;
        repeat (20) tick();
        chk("stall_s_tready", s_tready, 1'b0);
        chk("stall_max_two_words", (acc_cnt - a0) <= 2 * PPB, 1'b1);
        r_mode = 0;
        run_until_done(1, 300);
        chk("stall_done_cnt", done_cnt, 1);
        chk("stall_nwords", wq.size(), W);
        check_frame("stall", 200, 0);
        chk("stall_hold", hold_viol, 0);

        // three back-to-back frames, random valid/ready, ap_start toggling during RUN
        clear_trk();
        starts_left = 3; pix_left = 3 * N; pix_val = 0; v_pct = 50; r_mode = 1; spam = 1'b1;
        run_until_done(3, 4000);
        spam = 1'b0; r_mode = 0;
        repeat (3) tick();
        chk("rnd_done_cnt", done_cnt, 3);
        chk("rnd_nwords", wq.size(), 3 * W);
        check_frame("rnd_f0", 0, 0);
        check_frame("rnd_f1", N, W);
        check_frame("rnd_f2", 2 * N, 2 * W);
        chk("rnd_gap_idle", gap_idle, 2);
        chk("rnd_hold", hold_viol, 0);
        chk("rnd_ready_vs_idle", rdy_viol, 0);

        // reset after 37 pixels, then a fresh frame
        clear_trk();
        v_pct = 100; starts_left = 1; pix_left = N; pix_val = 0;
        for (int c = 0; c < 200 && acc_cnt < 37; c++) tick();
        rst_n = 1'b0; s_tvalid = 1'b0; ap_start = 1'b0; pix_left = 0;
        #1;
        check_idle_outputs("rst_mid_outputs");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rst_mid_no_done", done_cnt, 0);
        clear_trk();
        starts_left = 1; pix_left = N; pix_val = 600;
        run_until_done(1, 300);
        chk("rst_new_done_cnt", done_cnt, 1);
        chk("rst_new_nwords", wq.size(), W);
        check_frame("rst_new", 600, 0);

        // 4x4 instance: two full words
        bq.delete();
        b_done = 0;
        b_ap_start = 1'b1;
        begin
            int  bp;
            logic bacc;
            bp = 0;
            for (int c = 0; c < 80 && b_done == 0; c++) begin
                @(negedge clk);
                bacc = b_s_tvalid && b_s_tready;
                @(posedge clk);
                #1;
                b_ap_start = 1'b0;
                if (bacc) bp++;
                b_s_tvalid = (bp < 16);
                b_s_tdata  = PW'(bp);
            end
        end
        repeat (2) @(posedge clk);
        chk("b16_done_cnt", b_done, 1);
        chk("b16_nwords", bq.size(), 2);
        chk("b16_w0", (bq.size() > 0) ? bq[0] : 'x, exp_word(0, 0, 16));
        chk("b16_w1", (bq.size() > 1) ? bq[1] : 'x, exp_word(0, 1, 16));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
